zero_pattern_gen: RTL and testbench
===================================

# zero_pattern_gen

Sequential inverse of the zero-count blocks. Given a requested zero count k (0..8), streams every 8-bit pattern containing exactly k zero bits, in ascending numeric order, one pattern per accepted beat over a valid/ready interface. It serves as a stimulus source for the zero counters and as a constant-weight code generator in the detection chapter.

## Interface
- ZP_WIDTH, 8: pattern width. Fixed at 8 for this block; the package constant is used, not a free parameter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse. Sampled only when busy=0.
- zero_cnt  in  4  requested zero count k. Valid values are 0..8.
- out_data  out  8  current pattern.
- out_valid  out  1  out_data holds a pattern.
- out_ready  in  1  sink accepts. A transfer occurs when out_valid && out_ready.
- out_last  out  1  out_data is the final pattern for k.
- out_idx  out  7  0-based index of the current pattern (max 69).
- busy  out  1  run in progress (RUN state).
- done  out  1  one-cycle pulse after the final transfer.
- err  out  1  one-cycle pulse when start arrives with zero_cnt>8.

## Operation
- FSM states: IDLE, RUN.
- **IDLE, start=1, zero_cnt<=8:**
  - Latch k and set m=8-k (number of ones).
  - Load out_data=(1<<m)-1, out_idx=0, out_valid=1.
  - Set out_last=1 if C(8,k)=1, i.e. k=0 (pattern 0xFF) or k=8 (pattern 0x00).
  - Go to RUN.
- **IDLE, start=1, zero_cnt>8:** err=1 for one cycle; stay in IDLE; no output.
- **RUN, transfer and out_last=0:**
  - out_data <= next_pattern(out_data); out_idx <= out_idx+1.
  - out_last <= (next pattern == (0xFF<<k)&0xFF).
- **RUN, transfer and out_last=1:** out_valid <= 0, done <= 1, return to IDLE.
- **RUN, no transfer:** out_data, out_idx and out_last hold unchanged (AXI-style stability). out_valid never drops without a transfer.
- **start while busy** is ignored. zero_cnt is not re-sampled mid-run.
- **next_pattern:** the next larger 8-bit value with equal popcount.
  - Find the lowest run of ones.
  - Move that run's top one up by one bit.
  - Pack the run's remaining ones down to bit 0.
  - It is never evaluated on the last pattern, so no wrap-around is defined or needed.
- Sequence length equals C(8,k): 1, 8, 28, 56, 70, 56, 28, 8, 1.
- Invariant: popcount(~out_data)=k on every beat.

## Timing
- Reset values: out_data=0x00, out_valid=0, out_last=0, out_idx=0, busy=0, done=0, err=0, state=IDLE.
- Latency: start sampled at edge t gives out_valid=1 with the first pattern after that edge (1 cycle).
- Throughput: one pattern per cycle while out_ready is held high. A 70-pattern run with out_ready=1 completes in 70 cycles after the first valid.
- done and err are registered, single-cycle pulses.
  - done asserts in the cycle after the last transfer, with busy=0.
  - A start in the done cycle is accepted, so back-to-back runs have a 1-cycle gap.
- Reset mid-run: at the reset edge all outputs return to their reset values, the run is abandoned, and no done is issued.
- start and a held transfer in the same cycle: the transfer is processed and start is ignored.

## Structure
- Package zp_pkg holds:
  - ZP_WIDTH=8, MAX_ZEROS=8, IDX_W=7.
  - State typedef enum {IDLE, RUN}.
  - Function n_choose_k_8 for bench use.
- Combinational sub-module zero_pattern_next: in [7:0] to out [7:0]. It implements the lowest-run move/pack without division, using a priority encoder for the trailing-zero count and shifts.
- The top module contains the FSM, the output registers and the last-pattern compare.

## Test plan
- **k=8:** start -> single beat 0x00 with out_last=1 and out_idx=0; done pulses the next cycle.
- **k=7, out_ready=1:** 8 beats 0x01,0x02,…,0x80; out_last only on 0x80; done follows.
- **k=4, out_ready randomly toggled:**
  - 70 beats; first 0x0F, last 0xF0.
  - Strictly ascending; popcount(~data)=4 on each beat.
  - data, idx and last stable while out_ready=0.
- **k=0, then back-to-back:** 0xFF with last; start asserted in the done cycle with k=6 is accepted: 28 beats, first 0x03, last 0xC0.
- **zero_cnt=9:** err=1 for exactly one cycle; out_valid stays 0; busy=0.
- **k=2 run, rst=1 at beat 5:** outputs at reset values next cycle; no done pulse. A new start with k=1 yields 0x7F,0xBF,0xDF,…,0xFE (8 beats).

Source files
------------

// File: rtl/zp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zp_pkg
// Purpose  : Shared constants, state type and helpers for zero_pattern_gen.
// Revision : 1.0 - initial release
// ============================================================================
package zp_pkg;

    localparam int ZP_WIDTH  = 8;
    localparam int MAX_ZEROS = 8;
    localparam int IDX_W     = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } zp_state_t;

    // Number of 8-bit patterns with exactly k zero bits (0 when k is out of range).
    function automatic int unsigned n_choose_k_8(input int unsigned k);
        int unsigned acc;
        acc = 1;
        if (k > 8) begin
            acc = 0;
        end else begin
            for (int unsigned i = 0; i < k; i++) begin
                acc = (acc * (8 - i)) / (i + 1);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zero_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : zero_pattern_gen_if
// Purpose  : Valid/ready pattern stream carrying data, index and last flag.
// Revision : 1.0 - initial release
// ============================================================================
interface zero_pattern_gen_if;
    import zp_pkg::*;

    logic [ZP_WIDTH-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [IDX_W-1:0]    out_idx;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_idx,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/zero_pattern_next.sv
`default_nettype none
// ============================================================================
// Module   : zero_pattern_next
// Purpose  : Next larger 8-bit value with the same popcount (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module zero_pattern_next
    import zp_pkg::*;
(
    input  wire logic [ZP_WIDTH-1:0] in_pat,
    output logic      [ZP_WIDTH-1:0] out_pat
);

    logic [3:0]          w_tz;
    logic [ZP_WIDTH-1:0] w_low;
    logic [ZP_WIDTH-1:0] w_ripple;
    logic [ZP_WIDTH-1:0] w_diff;
    logic [ZP_WIDTH-1:0] w_ones;

    // Priority encoder: position of the lowest set bit (8 when input is zero).
    always_comb begin
        w_tz = 4'd8;
        for (int i = ZP_WIDTH - 1; i >= 0; i--) begin
            if (in_pat[i]) begin
                w_tz = i[3:0];
            end
        end
    end

    // Adding the lowest one ripples the lowest run up by one bit; the bits it
    // cleared, shifted down past the run start, re-pack the leftover ones.
    assign w_low    = in_pat & (~in_pat + 8'd1);
    assign w_ripple = in_pat + w_low;
    assign w_diff   = w_ripple ^ in_pat;
    assign w_ones   = w_diff >> (w_tz + 4'd2);
    assign out_pat  = w_ripple | w_ones;

endmodule
`default_nettype wire

// File: rtl/zero_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : zero_pattern_gen
// Purpose  : Streams every 8-bit pattern with k zero bits in ascending order.
// Revision : 1.0 - initial release
// ============================================================================
module zero_pattern_gen
    import zp_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [3:0]         zero_cnt,
    zero_pattern_gen_if.master      out_if,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    zp_state_t           r_state;
    logic [3:0]          r_k;
    logic [ZP_WIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_last;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done;
    logic                r_err;

    logic [ZP_WIDTH-1:0] w_next;
    logic [ZP_WIDTH-1:0] w_last_pat;
    logic [ZP_WIDTH-1:0] w_first_pat;
    logic                w_xfer;
    logic                w_k_ok;
    logic                w_single;

    zero_pattern_next u_next (
        .in_pat  (r_data),
        .out_pat (w_next)
    );

    assign w_xfer      = r_valid & out_if.out_ready;
    assign w_k_ok      = (zero_cnt <= 4'(MAX_ZEROS));
    // Smallest pattern has its ones packed low; largest has them packed high.
    assign w_first_pat = 8'hFF >> zero_cnt;
    assign w_last_pat  = 8'hFF << r_k;
    assign w_single    = (zero_cnt == 4'd0) || (zero_cnt == 4'(MAX_ZEROS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 4'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_k_ok) begin
                            r_k     <= zero_cnt;
                            r_data  <= w_first_pat;
                            r_idx   <= '0;
                            r_valid <= 1'b1;
                            r_last  <= w_single;
                            r_state <= RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Without a transfer everything holds so the beat stays stable.
                    if (w_xfer) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_data <= w_next;
                            r_idx  <= r_idx + 7'd1;
                            r_last <= (w_next == w_last_pat);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_last;
    assign out_if.out_idx   = r_idx;
    assign busy             = (r_state == RUN);
    assign done             = r_done;
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_zero_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_zero_pattern_gen
// Purpose  : Self-checking bench: directed runs plus randomized backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zero_pattern_gen;
    import zp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] zero_cnt;
    logic       busy;
    logic       done;
    logic       err;

    zero_pattern_gen_if bus ();

    zero_pattern_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .zero_cnt (zero_cnt),
        .out_if   (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: enumerate all byte values, keep those with exactly k zeros.
    function automatic void build_model(input int k);
        logic [7:0] b;
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            if ($countones(~b) == k) exp_q.push_back(b);
        end
    endfunction

    // Called at a negedge with the DUT idle (or in its done cycle); returns at
    // the negedge of the done cycle.
    task automatic do_run(input int k, input int ready_pct);
        int         beat = 0;
        int         cycles = 0;
        bit         holding = 0;
        bit         fin = 0;
        logic [7:0] hd = '0;
        logic [6:0] hi = '0;
        logic       hl = 1'b0;
        build_model(k);
        start         = 1'b1;
        zero_cnt      = 4'(k);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        while (!fin && cycles < 1000) begin
            if (holding) begin
                chk("hold_data", 32'(bus.out_data), 32'(hd));
                chk("hold_idx", 32'(bus.out_idx), 32'(hi));
                chk("hold_last", 32'(bus.out_last), 32'(hl));
            end
            chk("valid_held", 32'(bus.out_valid), 32'd1);
            chk("no_err_busy", 32'(err), 32'd0);
            // Stray starts mid-run must be ignored.
            start    = 1'($urandom_range(1));
            zero_cnt = 4'($urandom_range(15));
            if (int'($urandom_range(99)) < ready_pct) begin
                bus.out_ready = 1'b1;
                holding       = 0;
                chk("data", 32'(bus.out_data), 32'(exp_q[beat]));
                chk("idx", 32'(bus.out_idx), 32'(beat));
                chk("last", 32'(bus.out_last), 32'(beat == exp_q.size() - 1));
                beat++;
                if (beat == exp_q.size()) fin = 1;
            end else begin
                bus.out_ready = 1'b0;
                holding       = 1;
                hd            = bus.out_data;
                hi            = bus.out_idx;
                hl            = bus.out_last;
            end
            @(negedge clk);
            cycles++;
        end
        start         = 1'b0;
        bus.out_ready = 1'b0;
        if (!fin) chk("run_timeout", 32'(beat), 32'(exp_q.size()));
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_after", 32'(bus.out_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        if (ready_pct >= 100) chk("throughput", 32'(cycles), 32'(exp_q.size()));
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        zero_cnt      = 4'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus.out_data), 32'h00);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_run(8, 100);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);

        do_run(7, 100);
        @(negedge clk);

        do_run(4, 50);
        @(negedge clk);

        // Back-to-back: start for k=6 lands in the done cycle of the k=0 run.
        do_run(0, 100);
        do_run(6, 70);
        @(negedge clk);

        start    = 1'b1;
        zero_cnt = 4'd9;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_valid", 32'(bus.out_valid), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_single", 32'(err), 32'd0);
        chk("err_valid2", 32'(bus.out_valid), 32'd0);

        // Abandon a k=2 run with reset at beat 5.
        build_model(2);
        start    = 1'b1;
        zero_cnt = 4'd2;
        @(negedge clk);
        start         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_idx", 32'(bus.out_idx), 32'd5);
        chk("pre_rst_data", 32'(bus.out_data), 32'(exp_q[5]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data", 32'(bus.out_data), 32'h00);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_idx", 32'(bus.out_idx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("mid_rst_nodone", 32'(done), 32'd0);
        do_run(1, 100);

        repeat (4) begin
            @(negedge clk);
            do_run(int'($urandom_range(8)), int'($urandom_range(100, 30)));
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
